// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the unified memory-port arbiter.
package mem_arb_pkg;

    localparam int ARB_AW = 32;
    localparam int ARB_DW = 32;
    localparam int STRB_W = ARB_DW / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and external-memory handshakes around the arbiter.
// slave = the arbiter itself; master = pipeline plus memory (the environment).
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int AW = ARB_AW,
    parameter int DW = ARB_DW
);

    logic              if_req;
    logic [AW-1:0]     if_addr;
    logic              if_flush;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DW-1:0]     if_rdata;

    logic              d_req;
    logic              d_we;
    logic [DW/8-1:0]   d_wstrb;
    logic [AW-1:0]     d_addr;
    logic [DW-1:0]     d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DW-1:0]     d_rdata;

    logic              m_req;
    logic              m_we;
    logic [DW/8-1:0]   m_wstrb;
    logic [AW-1:0]     m_addr;
    logic [DW-1:0]     m_wdata;
    logic              m_ack;
    logic              m_rvalid;
    logic [DW-1:0]     m_rdata;

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_wstrb, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output m_req, m_we, m_wstrb, m_addr, m_wdata,
        input  m_ack, m_rvalid, m_rdata
    );

    modport master (
        output if_req, if_addr, if_flush,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_wstrb, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_req, m_we, m_wstrb, m_addr, m_wdata,
        output m_ack, m_rvalid, m_rdata
    );

endinterface

// File: rtl/arb_starve_ctr.sv
// Fetch-starvation guard: counts data grants made while a fetch waits and
// raises force_fetch at STARVE_MAX. Exists only when ARB_STARVE_GUARD_EN is defined.
`ifdef ARB_STARVE_GUARD_EN
module arb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic data_grant,
    input  logic fetch_grant,
    output logic force_fetch
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_cnt;

    // Any gap in the fetch request or a granted fetch ends the starvation run.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!if_req || fetch_grant) begin
            starve_cnt <= '0;
        end else if (data_grant && (starve_cnt != CW'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

    assign force_fetch = if_req && (starve_cnt == CW'(STARVE_MAX));

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, one
// transaction at a time. Optional fetch-starvation guard: ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = ARB_AW,
    parameter int DW = ARB_DW
`ifdef ARB_STARVE_GUARD_EN
    , parameter int STARVE_MAX = 4
`endif
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam int SW = DW / 8;

    state_t          state_q, state_d;
    owner_t          owner_q, owner_d;
    logic            flush_pend_q, flush_pend_d;

    logic            if_gnt_q, if_gnt_d;
    logic            if_rvalid_q, if_rvalid_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic            d_gnt_q, d_gnt_d;
    logic            d_rvalid_q, d_rvalid_d;
    logic [DW-1:0]   d_rdata_q, d_rdata_d;
    logic            m_req_q, m_req_d;
    logic            m_we_q, m_we_d;
    logic [SW-1:0]   m_wstrb_q, m_wstrb_d;
    logic [AW-1:0]   m_addr_q, m_addr_d;
    logic [DW-1:0]   m_wdata_q, m_wdata_d;

    logic            force_fetch;
    logic            pick_data;
    logic            resp_now;
    logic            fetch_killed;

    // Data wins unless the guard has seen the fetch side starve long enough.
    assign pick_data = bus.d_req && !force_fetch;

`ifdef ARB_STARVE_GUARD_EN
    logic data_grant;
    logic fetch_grant;

    assign data_grant  = (state_q == IDLE) && pick_data;
    assign fetch_grant = (state_q == IDLE) && bus.if_req && !pick_data;

    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk         (clk),
        .rst         (rst),
        .if_req      (bus.if_req),
        .data_grant  (data_grant),
        .fetch_grant (fetch_grant),
        .force_fetch (force_fetch)
    );
`else
    assign force_fetch = 1'b0;
`endif

    // The response lands either with the accepting m_ack or later while waiting.
    assign resp_now = bus.m_rvalid &&
                      (((state_q == ISSUE) && bus.m_ack) || (state_q == WAIT));

    // A flush arriving in the same cycle as the response must also kill it.
    assign fetch_killed = flush_pend_q || bus.if_flush;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        flush_pend_d = flush_pend_q;
        if_gnt_d     = 1'b0;
        if_rvalid_d  = 1'b0;
        if_rdata_d   = '0;
        d_gnt_d      = 1'b0;
        d_rvalid_d   = 1'b0;
        d_rdata_d    = '0;
        m_req_d      = m_req_q;
        m_we_d       = m_we_q;
        m_wstrb_d    = m_wstrb_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;

        if ((state_q != IDLE) && (owner_q == FETCH) && bus.if_flush) begin
            flush_pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.d_req || bus.if_req) begin
                    state_d = ISSUE;
                    m_req_d = 1'b1;
                    if (pick_data) begin
                        owner_d   = DATA;
                        d_gnt_d   = 1'b1;
                        m_we_d    = bus.d_we;
                        m_wstrb_d = bus.d_wstrb;
                        m_addr_d  = bus.d_addr;
                        m_wdata_d = bus.d_wdata;
                    end else begin
                        owner_d   = FETCH;
                        if_gnt_d  = 1'b1;
                        m_we_d    = 1'b0;
                        m_wstrb_d = '0;
                        m_addr_d  = bus.if_addr;
                        m_wdata_d = '0;
                    end
                end
            end
            ISSUE: begin
                if (bus.m_ack) begin
                    m_req_d = 1'b0;
                    state_d = bus.m_rvalid ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (bus.m_rvalid) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d      = IDLE;
                owner_d      = NONE;
                flush_pend_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                owner_d = NONE;
            end
        endcase

        if (resp_now) begin
            if (owner_q == DATA) begin
                d_rvalid_d = 1'b1;
                d_rdata_d  = m_we_q ? '0 : bus.m_rdata;
            end else if ((owner_q == FETCH) && !fetch_killed) begin
                if_rvalid_d = 1'b1;
                if_rdata_d  = bus.m_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= NONE;
            flush_pend_q <= 1'b0;
            if_gnt_q     <= 1'b0;
            if_rvalid_q  <= 1'b0;
            if_rdata_q   <= '0;
            d_gnt_q      <= 1'b0;
            d_rvalid_q   <= 1'b0;
            d_rdata_q    <= '0;
            m_req_q      <= 1'b0;
            m_we_q       <= 1'b0;
            m_wstrb_q    <= '0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            flush_pend_q <= flush_pend_d;
            if_gnt_q     <= if_gnt_d;
            if_rvalid_q  <= if_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            d_gnt_q      <= d_gnt_d;
            d_rvalid_q   <= d_rvalid_d;
            d_rdata_q    <= d_rdata_d;
            m_req_q      <= m_req_d;
            m_we_q       <= m_we_d;
            m_wstrb_q    <= m_wstrb_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
        end
    end

    assign bus.if_gnt    = if_gnt_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_gnt     = d_gnt_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.m_req     = m_req_q;
    assign bus.m_we      = m_we_q;
    assign bus.m_wstrb   = m_wstrb_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_wdata   = m_wdata_q;

endmodule
